// File: rtl/update_mask_pkg.sv
// Shared types and helpers for the sparse-mask updater and its pruning compare.
package update_mask_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Encoding 2'b11 is reserved and behaves like ZERO.
    typedef enum logic [1:0] {
        ZERO   = 2'b00,
        THR    = 2'b01,
        NONPOS = 2'b10
    } mode_e;

    // Width of a counter that can hold 0..length inclusive.
    function automatic int nnz_width(input int length);
        return $clog2(length + 1);
    endfunction

endpackage

// File: rtl/mask_prune_cmp.sv
// Combinational keep/clear decision for one fixed-point value under a pruning mode.
module mask_prune_cmp
    import update_mask_pkg::*;
#(
    parameter int IL = 8,
    parameter int FL = 12,
    localparam int W = IL + FL
) (
    input  logic signed [W-1:0] v,
    input  logic [1:0]          mode,
    input  logic [W-1:0]        thr,
    output logic                keep
);

    logic [W-1:0] mag;

    // Unsigned magnitude; the most negative value yields 2^(W-1), which still fits in W bits.
    always_comb begin
        mag  = v[W-1] ? (~unsigned'(v) + W'(1)) : unsigned'(v);
        keep = 1'b0;
        case (mode)
            THR:     keep = (mag > thr);
            NONPOS:  keep = !v[W-1] && (v != '0);
            default: keep = (v != '0);
        endcase
    end

endmodule

// File: rtl/update_mask_gen.sv
// Walks a latched mask one bit per cycle, pairing set bits with successive values
// and keeping or clearing each according to the selected pruning mode.
// Handshake: a job transfers on a rising edge where in_valid && in_ready; a result
// transfers on a rising edge where out_valid && out_ready. in_ready/out_valid are
// pure decodes of state, so neither depends combinationally on the other side.
module update_mask_gen
    import update_mask_pkg::*;
#(
    parameter int IL     = 8,
    parameter int FL     = 12,
    parameter int LENGTH = 32,
    parameter int N_VAL  = 16,
    localparam int W     = IL + FL,
    localparam int NW    = nnz_width(LENGTH)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [LENGTH-1:0]   i_mask,
    input  logic signed [W-1:0] i_val [N_VAL],
    input  logic [1:0]          i_mode,
    input  logic [W-1:0]        i_thr,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [LENGTH-1:0]   o_mask,
    output logic [NW-1:0]       o_nnz,
    output logic                o_ovf,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [1:0]          state
);

    localparam int MPW = $clog2(LENGTH);
    localparam int VPW = $clog2(N_VAL + 1);

    state_e              state_q, state_d;
    logic [LENGTH-1:0]   mask_q, mask_d;
    logic signed [W-1:0] val_q [N_VAL];
    logic signed [W-1:0] val_d [N_VAL];
    logic [1:0]          mode_q, mode_d;
    logic [W-1:0]        thr_q, thr_d;
    logic [MPW-1:0]      m_ptr_q, m_ptr_d;
    logic [VPW-1:0]      v_ptr_q, v_ptr_d;
    logic [LENGTH-1:0]   o_mask_q, o_mask_d;
    logic [NW-1:0]       o_nnz_q, o_nnz_d;
    logic                o_ovf_q, o_ovf_d;

    logic signed [W-1:0] cur_val;
    logic                keep;

    mask_prune_cmp #(.IL(IL), .FL(FL)) u_cmp (
        .v    (cur_val),
        .mode (mode_q),
        .thr  (thr_q),
        .keep (keep)
    );

    // Value at v_ptr; once all values are used (v_ptr==N_VAL) this reads zero and is unused.
    always_comb begin
        cur_val = '0;
        for (int i = 0; i < N_VAL; i++) begin
            if (v_ptr_q == VPW'(i)) cur_val = val_q[i];
        end
    end

    // Next-state and datapath update for accept, per-bit processing and result release.
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        mode_d   = mode_q;
        thr_d    = thr_q;
        m_ptr_d  = m_ptr_q;
        v_ptr_d  = v_ptr_q;
        o_mask_d = o_mask_q;
        o_nnz_d  = o_nnz_q;
        o_ovf_d  = o_ovf_q;
        for (int i = 0; i < N_VAL; i++) val_d[i] = val_q[i];

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mask_d   = i_mask;
                    for (int i = 0; i < N_VAL; i++) val_d[i] = i_val[i];
                    mode_d   = i_mode;
                    thr_d    = i_thr;
                    m_ptr_d  = '0;
                    v_ptr_d  = '0;
                    o_mask_d = '0;
                    o_nnz_d  = '0;
                    o_ovf_d  = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                m_ptr_d = m_ptr_q + MPW'(1);
                o_mask_d[m_ptr_q] = 1'b0;
                if (mask_q[m_ptr_q]) begin
                    if (v_ptr_q != VPW'(N_VAL)) begin
                        o_mask_d[m_ptr_q] = keep;
                        if (keep) o_nnz_d = o_nnz_q + NW'(1);
                        v_ptr_d = v_ptr_q + VPW'(1);
                    end else begin
                        o_ovf_d = 1'b1;
                    end
                end
                if (m_ptr_q == MPW'(LENGTH - 1)) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            for (int i = 0; i < N_VAL; i++) val_q[i] <= '0;
            mode_q   <= '0;
            thr_q    <= '0;
            m_ptr_q  <= '0;
            v_ptr_q  <= '0;
            o_mask_q <= '0;
            o_nnz_q  <= '0;
            o_ovf_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            for (int i = 0; i < N_VAL; i++) val_q[i] <= val_d[i];
            mode_q   <= mode_d;
            thr_q    <= thr_d;
            m_ptr_q  <= m_ptr_d;
            v_ptr_q  <= v_ptr_d;
            o_mask_q <= o_mask_d;
            o_nnz_q  <= o_nnz_d;
            o_ovf_q  <= o_ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign o_mask    = o_mask_q;
    assign o_nnz     = o_nnz_q;
    assign o_ovf     = o_ovf_q;
    assign state     = state_q;

endmodule

// File: tb/tb_update_mask_gen.sv
// Bench for update_mask_gen: vector table, handshake hold, mid-job reset and random jobs.
module tb_update_mask_gen;

    localparam int IL     = 8;
    localparam int FL     = 12;
    localparam int W      = IL + FL;
    localparam int LENGTH = 32;
    localparam int N_VAL  = 16;
    localparam int NW     = 6;
    localparam int EW     = LENGTH + NW + 1;
    localparam int NVEC   = 9;

    typedef struct packed {
        logic [LENGTH-1:0]  mask;
        logic [N_VAL*W-1:0] vals;
        logic [1:0]         mode;
        logic [W-1:0]       thr;
        logic [LENGTH-1:0]  exp_mask;
        logic [NW-1:0]      exp_nnz;
        logic               exp_ovf;
    } vec_t;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [LENGTH-1:0]   i_mask = '0;
    logic signed [W-1:0] i_val [N_VAL];
    logic [1:0]          i_mode = '0;
    logic [W-1:0]        i_thr = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [LENGTH-1:0]   o_mask;
    logic [NW-1:0]       o_nnz;
    logic                o_ovf;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [1:0]          state;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] last_exp;
    vec_t          tv [NVEC];
    int            n_checks = 0;
    int            n_fail = 0;

    update_mask_gen #(.IL(IL), .FL(FL), .LENGTH(LENGTH), .N_VAL(N_VAL)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_mask    (i_mask),
        .i_val     (i_val),
        .i_mode    (i_mode),
        .i_thr     (i_thr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .o_mask    (o_mask),
        .o_nnz     (o_nnz),
        .o_ovf     (o_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state     (state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: walk the mask, consuming values in order.
    function automatic logic [EW-1:0] exp_model(input logic [LENGTH-1:0] mask,
                                                input logic [N_VAL*W-1:0] vals,
                                                input logic [1:0] mode,
                                                input logic [W-1:0] thr);
        int                  vp;
        int                  nnz;
        logic [LENGTH-1:0]   m;
        logic                ovf;
        logic signed [W-1:0] v;
        longint              mag;
        logic                k;
        vp = 0; nnz = 0; m = '0; ovf = 1'b0;
        for (int b = 0; b < LENGTH; b++) begin
            if (mask[b]) begin
                if (vp < N_VAL) begin
                    v   = vals[vp*W +: W];
                    mag = (v < 0) ? -longint'(v) : longint'(v);
                    if (mode == 2'b01)      k = (mag > longint'({1'b0, thr}));
                    else if (mode == 2'b10) k = (v > 0);
                    else                    k = (v != 0);
                    m[b] = k;
                    if (k) nnz++;
                    vp++;
                end else begin
                    ovf = 1'b1;
                end
            end
        end
        return {m, NW'(nnz), ovf};
    endfunction

    task automatic drive_inputs(input logic [LENGTH-1:0] mask, input logic [N_VAL*W-1:0] vals,
                                input logic [1:0] mode, input logic [W-1:0] thr);
        i_mask = mask;
        for (int i = 0; i < N_VAL; i++) i_val[i] = vals[i*W +: W];
        i_mode = mode;
        i_thr  = thr;
    endtask

    task automatic start_job(input logic [LENGTH-1:0] mask, input logic [N_VAL*W-1:0] vals,
                             input logic [1:0] mode, input logic [W-1:0] thr,
                             input logic [EW-1:0] exp);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        check("in_ready_idle", in_ready, 1);
        drive_inputs(mask, vals, mode, thr);
        in_valid = 1'b1;
        exp_q.push_back(exp);
        tick();
        in_valid = 1'b0;
        check("state_run_after_accept", state, 2'b01);
        check("in_ready_low_in_run", in_ready, 0);
    endtask

    task automatic wait_done();
        int edges;
        edges = 0;
        while (!out_valid && edges < 100) begin
            tick();
            edges++;
        end
        check("latency_edges", edges, LENGTH);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
            last_exp = '0;
        end else begin
            last_exp = exp_q.pop_front();
        end
        check("o_mask", o_mask, last_exp[EW-1 -: LENGTH]);
        check("o_nnz", o_nnz, last_exp[NW:1]);
        check("o_ovf", o_ovf, last_exp[0]);
    endtask

    task automatic release_job();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("state_idle_after_release", state, 2'b00);
        check("o_mask_held_idle", o_mask, last_exp[EW-1 -: LENGTH]);
    endtask

    initial begin
        logic [N_VAL*W-1:0] rv;
        logic [LENGTH-1:0]  rm;
        logic [1:0]         rmode;
        logic [W-1:0]       rthr;
        logic [EW-1:0]      e;

        for (int i = 0; i < N_VAL; i++) i_val[i] = '0;

        // Vector table: inputs and hand-derived expected results.
        for (int n = 0; n < NVEC; n++) tv[n] = '0;
        tv[0].mask = 32'h0000FFFF; tv[0].mode = 2'b00;
        for (int i = 0; i < N_VAL; i++) tv[0].vals[i*W +: W] = W'(i);
        tv[0].exp_mask = 32'h0000FFFE; tv[0].exp_nnz = 15; tv[0].exp_ovf = 0;

        tv[1].mask = 32'h80000001; tv[1].mode = 2'b01; tv[1].thr = 20'h00100;
        tv[1].vals[0 +: W] = 20'h00100; tv[1].vals[W +: W] = 20'hFFE00;
        tv[1].exp_mask = 32'h80000000; tv[1].exp_nnz = 1; tv[1].exp_ovf = 0;

        tv[2].mask = 32'hFFFFFFFF; tv[2].mode = 2'b10;
        for (int i = 0; i < N_VAL; i++) tv[2].vals[i*W +: W] = (i % 2 == 0) ? 20'h00001 : 20'hFFFFF;
        tv[2].exp_mask = 32'h00005555; tv[2].exp_nnz = 8; tv[2].exp_ovf = 1;

        tv[3].mask = 32'h00000001; tv[3].mode = 2'b01; tv[3].thr = 20'h7FFFF;
        tv[3].vals[0 +: W] = 20'h80000;
        tv[3].exp_mask = 32'h00000001; tv[3].exp_nnz = 1; tv[3].exp_ovf = 0;

        tv[4].mask = 32'h0000000F; tv[4].mode = 2'b11;
        tv[4].vals[W +: W] = 20'h00005; tv[4].vals[3*W +: W] = 20'hFFFFD;
        tv[4].exp_mask = 32'h0000000A; tv[4].exp_nnz = 2; tv[4].exp_ovf = 0;

        tv[5].mask = 32'h00000002; tv[5].mode = 2'b01; tv[5].thr = 20'h80000;
        tv[5].vals[0 +: W] = 20'h80000;
        tv[5].exp_mask = 32'h00000000; tv[5].exp_nnz = 0; tv[5].exp_ovf = 0;

        tv[6].mask = 32'h00000000; tv[6].mode = 2'b10;
        tv[6].vals[0 +: W] = 20'h00003;
        tv[6].exp_mask = 32'h00000000; tv[6].exp_nnz = 0; tv[6].exp_ovf = 0;

        tv[7].mask = 32'hFFFF0000; tv[7].mode = 2'b00;
        for (int i = 0; i < N_VAL; i++) tv[7].vals[i*W +: W] = 20'h00007;
        tv[7].exp_mask = 32'hFFFF0000; tv[7].exp_nnz = 16; tv[7].exp_ovf = 0;

        tv[8].mask = 32'hFFFF8000; tv[8].mode = 2'b00;
        for (int i = 0; i < N_VAL; i++) tv[8].vals[i*W +: W] = 20'h00007;
        tv[8].exp_mask = 32'h7FFF8000; tv[8].exp_nnz = 16; tv[8].exp_ovf = 1;

        // Reset
        reset_n = 1'b0;
        repeat (3) tick();
        check("rst_state", state, 2'b00);
        check("rst_o_mask", o_mask, 0);
        check("rst_o_nnz", o_nnz, 0);
        check("rst_o_ovf", o_ovf, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        reset_n = 1'b1;
        tick();

        // Table vectors
        for (int n = 0; n < NVEC; n++) begin
            start_job(tv[n].mask, tv[n].vals, tv[n].mode, tv[n].thr,
                      {tv[n].exp_mask, tv[n].exp_nnz, tv[n].exp_ovf});
            wait_done();
            release_job();
        end

        // Hold the result in DONE while a new job is already offered.
        start_job(tv[0].mask, tv[0].vals, tv[0].mode, tv[0].thr,
                  {tv[0].exp_mask, tv[0].exp_nnz, tv[0].exp_ovf});
        wait_done();
        rv = '0;
        rv[0 +: W] = 20'h00001; rv[2*W +: W] = 20'hFFFFF; rv[3*W +: W] = 20'h00002;
        drive_inputs(32'h000000F0, rv, 2'b00, '0);
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("hold_state_done", state, 2'b10);
            check("hold_in_ready_low", in_ready, 0);
            check("hold_o_mask", o_mask, 32'h0000FFFE);
            check("hold_o_nnz", o_nnz, 15);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hs_state_idle", state, 2'b00);
        check("hs_in_ready", in_ready, 1);
        exp_q.push_back({32'h000000D0, NW'(3), 1'b0});
        tick();
        in_valid = 1'b0;
        check("hs_accept_next", state, 2'b01);
        wait_done();
        release_job();

        // Reset in the middle of a job abandons it.
        rv = '0;
        for (int i = 0; i < N_VAL; i++) rv[i*W +: W] = W'(i + 1);
        start_job(32'h0000FFFF, rv, 2'b00, '0, {32'h0000FFFF, NW'(16), 1'b0});
        repeat (10) tick();
        check("mid_run_partial_mask", o_mask, 32'h000003FF);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        void'(exp_q.pop_back());
        check("midrst_state", state, 2'b00);
        check("midrst_o_mask", o_mask, 0);
        check("midrst_o_nnz", o_nnz, 0);
        check("midrst_o_ovf", o_ovf, 0);
        start_job(tv[2].mask, tv[2].vals, tv[2].mode, tv[2].thr,
                  {tv[2].exp_mask, tv[2].exp_nnz, tv[2].exp_ovf});
        wait_done();
        release_job();

        // Random jobs against the reference model.
        for (int r = 0; r < 8; r++) begin
            rm    = $urandom;
            if (r % 3 == 0) rm = rm & $urandom;
            rmode = 2'($urandom_range(0, 3));
            rthr  = W'($urandom_range(0, 600));
            for (int i = 0; i < N_VAL; i++) rv[i*W +: W] = W'(int'($urandom_range(0, 1023)) - 512);
            e = exp_model(rm, rv, rmode, rthr);
            start_job(rm, rv, rmode, rthr, e);
            wait_done();
            release_job();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
